// File: rtl/dht11_uart_reporter.sv
// dht11_uart_reporter: turns each DHT11 measurement into an ASCII frame
// ("RH:hhh T:ttt" or "ERR" plus line ending) and streams it byte by byte
// into a UART transmitter over a tx_start/tx_busy handshake.
`timescale 1ns/1ps
module dht11_uart_reporter #(
  parameter int unsigned CRLF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_done,
  input  logic [7:0] rh_data,
  input  logic [7:0] t_data,
  input  logic       dht11_valid,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic [7:0] ovr_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [7:0] EOL = (CRLF != 0) ? 8'h0D : 8'h0A;

  logic [2:0]  state_q, state_d;
  logic [7:0]  act_rh_q, act_rh_d, act_t_q, act_t_d;
  logic        act_v_q, act_v_d;
  logic        pend_full_q, pend_full_d;
  logic [7:0]  pend_rh_q, pend_rh_d, pend_t_q, pend_t_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  idx_q, idx_d, last_q, last_d;
  logic        fv_q, fv_d;
  logic [23:0] dig_q, dig_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d, ovr_cnt_q, ovr_cnt_d;
  logic        take_pend, cap_direct;

  // Exact 0..255 -> three BCD digits {hundreds, tens, ones}
  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    logic [7:0] r;
    logic [3:0] h;
    if (v >= 8'd200) begin
      h = 4'd2; r = v - 8'd200;
    end else if (v >= 8'd100) begin
      h = 4'd1; r = v - 8'd100;
    end else begin
      h = 4'd0; r = v;
    end
    return {h, 4'(r / 8'd10), 4'(r % 8'd10)};
  endfunction

  // Frame byte at position idx; dig = {h2,h1,h0,t2,t1,t0}
  function automatic logic [7:0] frame_byte(input logic v, input logic [3:0] idx,
                                            input logic [23:0] dig);
    logic [7:0] b;
    b = 8'h0A;
    if (v) begin
      case (idx)
        4'd0:  b = 8'h52;
        4'd1:  b = 8'h48;
        4'd2:  b = 8'h3A;
        4'd3:  b = {4'h3, dig[23:20]};
        4'd4:  b = {4'h3, dig[19:16]};
        4'd5:  b = {4'h3, dig[15:12]};
        4'd6:  b = 8'h20;
        4'd7:  b = 8'h54;
        4'd8:  b = 8'h3A;
        4'd9:  b = {4'h3, dig[11:8]};
        4'd10: b = {4'h3, dig[7:4]};
        4'd11: b = {4'h3, dig[3:0]};
        4'd12: b = EOL;
        default: b = 8'h0A;
      endcase
    end else begin
      case (idx)
        4'd0:    b = 8'h45;
        4'd1:    b = 8'h52;
        4'd2:    b = 8'h52;
        4'd3:    b = EOL;
        default: b = 8'h0A;
      endcase
    end
    return b;
  endfunction

  // Capture/pending bookkeeping and frame sequencing
  always_comb begin
    state_d     = state_q;
    act_rh_d    = act_rh_q;
    act_t_d     = act_t_q;
    act_v_d     = act_v_q;
    pend_full_d = pend_full_q;
    pend_rh_d   = pend_rh_q;
    pend_t_d    = pend_t_q;
    pend_v_d    = pend_v_q;
    idx_d       = idx_q;
    last_d      = last_q;
    fv_d        = fv_q;
    dig_d       = dig_q;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    tx_start    = 1'b0;

    // Pending slot frees whenever IDLE/DONE promotes it; a capture in that
    // same cycle refills it without counting as an overwrite.
    take_pend  = pend_full_q && (state_q == S_IDLE || state_q == S_DONE);
    cap_direct = data_done && (state_q == S_IDLE) && !pend_full_q;

    if (take_pend) begin
      pend_full_d = 1'b0;
      act_rh_d    = pend_rh_q;
      act_t_d     = pend_t_q;
      act_v_d     = pend_v_q;
    end else if (cap_direct) begin
      act_rh_d = rh_data;
      act_t_d  = t_data;
      act_v_d  = dht11_valid;
    end
    if (data_done && !cap_direct) begin
      pend_full_d = 1'b1;
      pend_rh_d   = rh_data;
      pend_t_d    = t_data;
      pend_v_d    = dht11_valid;
      if (pend_full_q && !take_pend) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: if (take_pend || data_done) state_d = S_LOAD;
      S_LOAD: begin
        dig_d     = {to_bcd(act_rh_q), to_bcd(act_t_q)};
        fv_d      = act_v_q;
        idx_d     = 4'd0;
        last_d    = act_v_q ? ((CRLF != 0) ? 4'd13 : 4'd12)
                            : ((CRLF != 0) ? 4'd4  : 4'd3);
        tx_data_d = frame_byte(act_v_q, 4'd0, dig_d);
        state_d   = S_REQ;
      end
      S_REQ: begin
        if (!tx_busy) begin
          tx_start = rst;
          state_d  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (tx_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = frame_byte(fv_q, idx_q + 4'd1, dig_q);
            state_d   = S_REQ;
          end
        end
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = pend_full_q ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      act_rh_q    <= '0;
      act_t_q     <= '0;
      act_v_q     <= 1'b0;
      pend_full_q <= 1'b0;
      pend_rh_q   <= '0;
      pend_t_q    <= '0;
      pend_v_q    <= 1'b0;
      idx_q       <= '0;
      last_q      <= '0;
      fv_q        <= 1'b0;
      dig_q       <= '0;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      act_rh_q    <= act_rh_d;
      act_t_q     <= act_t_d;
      act_v_q     <= act_v_d;
      pend_full_q <= pend_full_d;
      pend_rh_q   <= pend_rh_d;
      pend_t_q    <= pend_t_d;
      pend_v_q    <= pend_v_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      fv_q        <= fv_d;
      dig_q       <= dig_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign ovr_cnt   = ovr_cnt_q;

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Directed bench for dht11_uart_reporter: a CRLF=1 and a CRLF=0 instance
// share stimulus; each drives its own simple UART model (10 cycles/byte).
`timescale 1ns/1ps
module tb_dht11_uart_reporter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic data_done = 1'b0;
  logic [7:0] rh_data = '0, t_data = '0;
  logic dht11_valid = 1'b0;

  logic tx_start0, tx_start1, busy0, busy1, tx_busy0, tx_busy1;
  logic [7:0] tx_data0, tx_data1, frame_cnt0, frame_cnt1, ovr_cnt0, ovr_cnt1;

  logic force_busy = 1'b0;
  logic stab_en = 1'b1;
  int mcnt0 = 0, mcnt1 = 0;
  logic [7:0] hold0 = '0, hold1 = '0;
  logic [7:0] q0[$], q1[$];
  int start_cnt0 = 0;
  logic prev_start0 = 1'b0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dht11_uart_reporter #(.CRLF(1)) dut0 (
    .clk(clk), .rst(rst), .data_done(data_done), .rh_data(rh_data), .t_data(t_data),
    .dht11_valid(dht11_valid), .tx_busy(tx_busy0), .tx_start(tx_start0), .tx_data(tx_data0),
    .busy(busy0), .frame_cnt(frame_cnt0), .ovr_cnt(ovr_cnt0));

  dht11_uart_reporter #(.CRLF(0)) dut1 (
    .clk(clk), .rst(rst), .data_done(data_done), .rh_data(rh_data), .t_data(t_data),
    .dht11_valid(dht11_valid), .tx_busy(tx_busy1), .tx_start(tx_start1), .tx_data(tx_data1),
    .busy(busy1), .frame_cnt(frame_cnt1), .ovr_cnt(ovr_cnt1));

  assign tx_busy0 = (mcnt0 != 0) || force_busy;
  assign tx_busy1 = (mcnt1 != 0);

  // UART models: accept on tx_start, busy from the next cycle for 10 cycles
  always @(posedge clk) begin
    if (mcnt0 != 0) mcnt0 <= mcnt0 - 1;
    else if (tx_start0 && !force_busy) begin
      mcnt0 <= 10; hold0 <= tx_data0; q0.push_back(tx_data0);
    end
    if (mcnt1 != 0) mcnt1 <= mcnt1 - 1;
    else if (tx_start1) begin
      mcnt1 <= 10; hold1 <= tx_data1; q1.push_back(tx_data1);
    end
  end

  // Handshake monitor on the CRLF=1 instance
  always @(negedge clk) begin
    if (tx_start0) begin
      checks++;
      assert (tx_busy0 === 1'b0) else begin errors++; $error("FAIL start_while_busy observed %b expected 0", tx_busy0); end
      checks++;
      assert (prev_start0 === 1'b0) else begin errors++; $error("FAIL start_back_to_back observed %b expected 0", prev_start0); end
      start_cnt0 <= start_cnt0 + 1;
    end
    prev_start0 <= tx_start0;
    if (stab_en && mcnt0 != 0) begin
      checks++;
      assert (tx_data0 === hold0) else begin errors++; $error("FAIL tx_data_stable observed %h expected %h", tx_data0, hold0); end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s observed %0h expected %0h", tag, obs, exp); end
  endtask

  task automatic pulse(input logic [7:0] rh, input logic [7:0] t, input logic v);
    @(negedge clk);
    rh_data = rh; t_data = t; dht11_valid = v; data_done = 1'b1;
    @(negedge clk);
    data_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy0 && !busy1 && !tx_busy0 && !tx_busy1) begin ok = 1'b1; break; end
    end
    chk({tag, "_done"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input string e0, input string e1);
    chk({tag, "_len0"}, q0.size(), e0.len());
    for (int i = 0; i < e0.len() && i < q0.size(); i++)
      chk($sformatf("%s_b0[%0d]", tag, i), {24'd0, q0[i]}, {24'd0, e0[i]});
    chk({tag, "_len1"}, q1.size(), e1.len());
    for (int i = 0; i < e1.len() && i < q1.size(); i++)
      chk($sformatf("%s_b1[%0d]", tag, i), {24'd0, q1[i]}, {24'd0, e1[i]});
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int sc;
    logic ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start0}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data0}, 32'h00);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_frame_cnt", {24'd0, frame_cnt0}, 32'd0);
    chk("rst_ovr_cnt", {24'd0, ovr_cnt0}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single valid frame with first-byte latency
    pulse(8'd45, 8'd23, 1'b1);
    chk("lat_load_start", {31'd0, tx_start0}, 32'd0);
    chk("lat_load_busy", {31'd0, busy0}, 32'd1);
    @(negedge clk);
    chk("lat_req_start", {31'd0, tx_start0}, 32'd1);
    chk("lat_req_data", {24'd0, tx_data0}, 32'h52);
    wait_idle("f45");
    check_frame("f45", "RH:045 T:023\r\n", "RH:045 T:023\n");
    chk("f45_frame_cnt", {24'd0, frame_cnt0}, 32'd1);
    chk("f45_busy", {31'd0, busy0}, 32'd0);

    // Error frame
    pulse(8'd45, 8'd23, 1'b0);
    wait_idle("err");
    check_frame("err", "ERR\r\n", "ERR\n");

    // Boundary digits
    pulse(8'd0, 8'd255, 1'b1);
    wait_idle("bnd");
    check_frame("bnd", "RH:000 T:255\r\n", "RH:000 T:255\n");
    chk("bnd_frame_cnt", {24'd0, frame_cnt0}, 32'd3);
    chk("bnd_frame_cnt1", {24'd0, frame_cnt1}, 32'd3);

    // Pending and overwrite: A, then B and C during A
    pulse(8'd1, 8'd2, 1'b1);
    repeat (20) @(negedge clk);
    pulse(8'd10, 8'd3, 1'b1);
    repeat (20) @(negedge clk);
    pulse(8'd99, 8'd4, 1'b1);
    wait_idle("pend");
    check_frame("pend", "RH:001 T:002\r\nRH:099 T:004\r\n", "RH:001 T:002\nRH:099 T:004\n");
    chk("pend_ovr_cnt", {24'd0, ovr_cnt0}, 32'd1);
    chk("pend_frame_cnt", {24'd0, frame_cnt0}, 32'd5);

    // Handshake: UART held busy for 50 cycles before the first byte
    force_busy = 1'b1;
    sc = start_cnt0;
    pulse(8'd7, 8'd8, 1'b1);
    repeat (50) @(negedge clk);
    chk("hs_no_start", start_cnt0, sc);
    force_busy = 1'b0;
    #1;
    chk("hs_release_start", {31'd0, tx_start0}, 32'd1);
    chk("hs_release_data", {24'd0, tx_data0}, 32'h52);
    wait_idle("hs");
    check_frame("hs", "RH:007 T:008\r\n", "RH:007 T:008\n");

    // Reset mid-frame after byte 5
    pulse(8'd45, 8'd23, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q0.size() >= 5) begin ok = 1'b1; break; end
    end
    chk("mid_reached5", {31'd0, ok}, 32'd1);
    rst = 1'b0;
    stab_en = 1'b0;
    @(negedge clk);
    chk("mid_tx_start", {31'd0, tx_start0}, 32'd0);
    chk("mid_tx_data", {24'd0, tx_data0}, 32'h00);
    chk("mid_busy", {31'd0, busy0}, 32'd0);
    chk("mid_frame_cnt", {24'd0, frame_cnt0}, 32'd0);
    chk("mid_ovr_cnt", {24'd0, ovr_cnt0}, 32'd0);
    rst = 1'b1;
    sc = start_cnt0;
    repeat (40) @(negedge clk);
    chk("mid_no_more_start", start_cnt0, sc);
    chk("mid_bytes", q0.size(), 32'd5);
    q0.delete();
    q1.delete();
    stab_en = 1'b1;
    pulse(8'd45, 8'd23, 1'b1);
    wait_idle("post");
    check_frame("post", "RH:045 T:023\r\n", "RH:045 T:023\n");
    chk("post_frame_cnt", {24'd0, frame_cnt0}, 32'd1);

    // Wrap: 256 error frames after a clean reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pulse(8'd0, 8'd0, 1'b0);
      wait_idle("wrap");
      q0.delete();
      q1.delete();
      if (i == 254) chk("wrap_255", {24'd0, frame_cnt0}, 32'd255);
    end
    chk("wrap_0", {24'd0, frame_cnt0}, 32'd0);
    chk("wrap_0_crlf0", {24'd0, frame_cnt1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
